// File: rtl/key_event_decoder_pkg.sv
// Shared constants for the key gesture decoder: one-hot FSM states and default timing.
// Timing defaults assume a 50 MHz clock, matching the key debouncer's interval constant.
package key_event_decoder_pkg;

   typedef enum logic [4:0] {
      StIdle   = 5'b00001,
      StPress1 = 5'b00010,
      StHold   = 5'b00100,
      StGap    = 5'b01000,
      StPress2 = 5'b10000
   } state_e;

   localparam int unsigned DefCntW       = 26;
   localparam logic [25:0] DefLongTime   = 26'd50_000_000;  // 1 s hold
   localparam logic [25:0] DefDblTime    = 26'd15_000_000;  // 300 ms release-to-press gap
   localparam logic [25:0] DefRepeatTime = 26'd10_000_000;  // repeat period minus 1

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced key press/release confirmations into short, long, repeat and
// double-click pulses, plus a pressed level that toggles on every confirmation.
module key_event_decoder
   import key_event_decoder_pkg::*;
#(
   parameter int unsigned      CNT_W       = DefCntW,
   parameter logic [CNT_W-1:0] LONG_TIME   = CNT_W'(DefLongTime),
   parameter logic [CNT_W-1:0] DBL_TIME    = CNT_W'(DefDblTime),
   parameter logic [CNT_W-1:0] REPEAT_TIME = CNT_W'(DefRepeatTime)
) (
   input  logic clk,
   input  logic rst,
   input  logic key_flag,
   output logic key_state,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic double_pulse
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_d, long_d, repeat_d, double_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      double_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (key_flag) begin
               state_d = StPress1;
            end
         end
         // A release always wins over the long-press threshold on the same cycle.
         StPress1: begin
            if (key_flag) begin
               state_d = StGap;
               cnt_d   = '0;
            end else if (cnt_q == LONG_TIME) begin
               long_d  = 1'b1;
               state_d = StHold;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StHold: begin
            if (key_flag) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (REPEAT_TIME == '0) begin
               cnt_d = '0;
            end else if (cnt_q == REPEAT_TIME) begin
               repeat_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // A second press on the timeout cycle still counts as a double click.
         StGap: begin
            if (key_flag) begin
               double_d = 1'b1;
               state_d  = StPress2;
               cnt_d    = '0;
            end else if (cnt_q == DBL_TIME) begin
               short_d = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPress2: begin
            cnt_d = '0;
            if (key_flag) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         double_pulse <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         short_pulse  <= short_d;
         long_pulse   <= long_d;
         repeat_pulse <= repeat_d;
         double_pulse <= double_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_state <= 1'b0;
      end else if (key_flag) begin
         key_state <= ~key_state;
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed gesture table, reset sequence and random flags
// checked cycle by cycle against a timestamp-based gesture model (two repeat settings).
module tb_key_event_decoder;

   localparam int LongT = 20;
   localparam int DblT  = 10;
   localparam int RepA  = 5;
   localparam int RepB  = 0;

   localparam int PhIdle   = 0;
   localparam int PhFirst  = 1;
   localparam int PhWait   = 2;
   localparam int PhSecond = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic key_flag = 1'b0;
   logic ks_a, sp_a, lp_a, rp_a, dp_a;
   logic ks_b, sp_b, lp_b, rp_b, dp_b;

   always #5 clk = ~clk;

   key_event_decoder #(
      .CNT_W(8), .LONG_TIME(8'd20), .DBL_TIME(8'd10), .REPEAT_TIME(8'd5)
   ) dut_a (
      .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(ks_a), .short_pulse(sp_a),
      .long_pulse(lp_a), .repeat_pulse(rp_a), .double_pulse(dp_a)
   );

   key_event_decoder #(
      .CNT_W(8), .LONG_TIME(8'd20), .DBL_TIME(8'd10), .REPEAT_TIME(8'd0)
   ) dut_b (
      .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(ks_b), .short_pulse(sp_b),
      .long_pulse(lp_b), .repeat_pulse(rp_b), .double_pulse(dp_b)
   );

   // Gesture model: phase of the gesture plus timestamps of the relevant flag/pulse cycles.
   typedef struct {
      bit ks;
      int phase;
      int t0;
      bit lng;
      int t_long;
      bit sp;
      bit lp;
      bit rp;
      bit dp;
   } model_t;

   function automatic model_t model_zero();
      model_t m;
      m.ks = 0; m.phase = PhIdle; m.t0 = 0; m.lng = 0; m.t_long = 0;
      m.sp = 0; m.lp = 0; m.rp = 0; m.dp = 0;
      return m;
   endfunction

   // f is the flag sampled at the end of cycle c; result describes cycle c+1.
   function automatic model_t model_step(model_t m, bit f, int c, int rt);
      model_t n;
      n = m;
      n.sp = 0; n.lp = 0; n.rp = 0; n.dp = 0;
      if (f) n.ks = !m.ks;
      case (m.phase)
         PhIdle: if (f) begin n.phase = PhFirst; n.t0 = c; n.lng = 0; end
         PhFirst: begin
            if (f) begin
               if (m.lng) n.phase = PhIdle;
               else begin n.phase = PhWait; n.t0 = c; end
            end else if (!m.lng) begin
               if (c - m.t0 == LongT + 1) begin n.lp = 1; n.lng = 1; n.t_long = c + 1; end
            end else if (rt != 0 && c + 1 > m.t_long && (c + 1 - m.t_long) % (rt + 1) == 0) begin
               n.rp = 1;
            end
         end
         PhWait: begin
            if (f) begin n.dp = 1; n.phase = PhSecond; end
            else if (c - m.t0 == DblT + 1) begin n.sp = 1; n.phase = PhIdle; end
         end
         default: if (f) n.phase = PhIdle;
      endcase
      return n;
   endfunction

   model_t ma, mb;
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int base;
   int s_at, s_n, l_at, l_n, d_at, d_n, r_at, r_n, lb_at, lb_n, rb_n;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic compare_all();
      check("a_key_state", int'(ks_a), int'(ma.ks));
      check("a_short", int'(sp_a), int'(ma.sp));
      check("a_long", int'(lp_a), int'(ma.lp));
      check("a_repeat", int'(rp_a), int'(ma.rp));
      check("a_double", int'(dp_a), int'(ma.dp));
      check("b_key_state", int'(ks_b), int'(mb.ks));
      check("b_short", int'(sp_b), int'(mb.sp));
      check("b_long", int'(lp_b), int'(mb.lp));
      check("b_repeat", int'(rp_b), int'(mb.rp));
      check("b_double", int'(dp_b), int'(mb.dp));
      check("a_pulse_onehot", int'((32'(sp_a) + 32'(lp_a) + 32'(rp_a) + 32'(dp_a)) <= 1), 1);
   endtask

   task automatic clear_rec();
      base = cyc;
      s_at = -1; s_n = 0; l_at = -1; l_n = 0; d_at = -1; d_n = 0; r_at = -1; r_n = 0;
      lb_at = -1; lb_n = 0; rb_n = 0;
   endtask

   // One clock cycle: drive flag/reset for the current cycle, then check the next one.
   task automatic tick(input bit f, input bit r);
      int rel;
      @(negedge clk);
      key_flag = f;
      rst = r;
      if (!r) begin
         #1;
         ma = model_zero();
         mb = model_zero();
         compare_all();
      end
      @(posedge clk);
      if (!r) begin
         ma = model_zero();
         mb = model_zero();
      end else begin
         ma = model_step(ma, f, cyc, RepA);
         mb = model_step(mb, f, cyc, RepB);
      end
      cyc++;
      #1;
      compare_all();
      rel = cyc - base;
      if (sp_a) begin if (s_n == 0) s_at = rel; s_n++; end
      if (lp_a) begin if (l_n == 0) l_at = rel; l_n++; end
      if (dp_a) begin if (d_n == 0) d_at = rel; d_n++; end
      if (rp_a) begin if (r_n == 0) r_at = rel; r_n++; end
      if (lp_b) begin if (lb_n == 0) lb_at = rel; lb_n++; end
      if (rp_b) rb_n++;
   endtask

   typedef struct {
      int f0, f1, f2, f3, len;
      int s_at, s_n, l_at, l_n, d_at, d_n, r_at, r_n;
   } scen_t;

   scen_t scen[6];

   initial begin
      int gap;
      int sel;
      int boundary[6];
      bit f;
      bit r;

      // flags..., len | short at/n, long at/n, double at/n, repeat(A) at/n
      scen[0] = '{0, 5, -1, -1, 30,   17, 1, -1, 0, -1, 0, -1, 0};
      scen[1] = '{0, 39, -1, -1, 50,  -1, 0, 22, 1, -1, 0, 28, 2};
      scen[2] = '{0, 3, 8, 12, 30,    -1, 0, -1, 0, 9, 1, -1, 0};
      scen[3] = '{0, 21, -1, -1, 40,  33, 1, -1, 0, -1, 0, -1, 0};
      scen[4] = '{0, 3, 14, 16, 30,   -1, 0, -1, 0, 15, 1, -1, 0};
      scen[5] = '{0, 60, -1, -1, 70,  -1, 0, 22, 1, -1, 0, 28, 6};
      boundary = '{10, 11, 12, 20, 21, 22};

      ma = model_zero();
      mb = model_zero();
      #1;
      compare_all();
      clear_rec();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         clear_rec();
         for (int t = 0; t < scen[i].len; t++) begin
            f = (t == scen[i].f0) || (t == scen[i].f1) || (t == scen[i].f2) || (t == scen[i].f3);
            tick(f, 1'b1);
         end
         check($sformatf("s%0d_short_at", i), s_at, scen[i].s_at);
         check($sformatf("s%0d_short_n", i), s_n, scen[i].s_n);
         check($sformatf("s%0d_long_at", i), l_at, scen[i].l_at);
         check($sformatf("s%0d_long_n", i), l_n, scen[i].l_n);
         check($sformatf("s%0d_double_at", i), d_at, scen[i].d_at);
         check($sformatf("s%0d_double_n", i), d_n, scen[i].d_n);
         check($sformatf("s%0d_repeat_at", i), r_at, scen[i].r_at);
         check($sformatf("s%0d_repeat_n", i), r_n, scen[i].r_n);
         check($sformatf("s%0d_b_long_at", i), lb_at, scen[i].l_at);
         check($sformatf("s%0d_b_repeat_n", i), rb_n, 0);
      end

      // Reset during a hold discards the gesture; a later click decodes normally.
      clear_rec();
      for (int t = 0; t < 50; t++) begin
         f = (t == 0) || (t == 30) || (t == 32);
         r = !(t >= 15 && t < 18);
         tick(f, r);
      end
      check("rst_long_n", l_n, 0);
      check("rst_b_long_n", lb_n, 0);
      check("rst_short_at", s_at, 44);
      check("rst_short_n", s_n, 1);
      check("rst_double_n", d_n, 0);

      // Random flag spacing biased toward the timing boundaries, with rare resets.
      clear_rec();
      gap = 0;
      for (int i = 0; i < 4000; i++) begin
         f = (gap == 0);
         if (f) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
               0: gap = 0;
               1, 2: gap = boundary[$urandom_range(0, 5)];
               3: gap = int'($urandom_range(1, 9));
               default: gap = int'($urandom_range(1, 45));
            endcase
         end else begin
            gap--;
         end
         r = ($urandom_range(0, 299) != 0);
         tick(f, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
